// File: rtl/key_debounce.sv
// Key debouncer: 2-flop synchronizer, 4-state qualification FSM, stability counter.
// Optional rising-edge press counter enabled by defining KEY_DEBOUNCE_PRESS_CNT_EN.
module key_debounce #(
    parameter int CNT_MAX    = 20,
    parameter int CNT_W      = 5,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       KEY_IN,
    output logic       KEY_LEVEL,
    output logic       KEY_RISE,
    output logic       KEY_FALL,
    output logic       BUSY
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
    ,
    output logic [7:0] PRESS_CNT
`endif
);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             s1_q, s2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q, rise_q, fall_q, busy_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= KEY_IN ^ ACTIVE_LOW;
            s2_q <= s1_q;
        end
    end

    // Pulses default low each cycle so they last exactly one clock.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (s2_q) begin
                        state_q <= CHECK_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK_HIGH: begin
                    if (!s2_q) begin
                        state_q <= IDLE_LOW;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_HIGH;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!s2_q) begin
                        state_q <= CHECK_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK_LOW: begin
                    if (s2_q) begin
                        state_q <= IDLE_HIGH;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_LOW;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign KEY_LEVEL = level_q;
    assign KEY_RISE  = rise_q;
    assign KEY_FALL  = fall_q;
    assign BUSY      = busy_q;

`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
    logic [7:0] press_q;

    // 8-bit counter wraps naturally from 255 to 0.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) press_q <= '0;
        else if (rise_q) press_q <= press_q + 8'd1;
    end

    assign PRESS_CNT = press_q;
`endif

endmodule
